dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for MEM-stage load/store traffic. Owns the data memory array.
//   Accepts one request at a time over a valid/ready handshake and converts each request into byte-lane form:
//     - stores: lane strobes plus shifted data;
//     - loads: the addressed lanes are shifted down to bit 0.
//   Returns a single-cycle response. Sign/zero extension of load data is NOT done here; it stays with the MEM-stage filter.
// PARAMETERS
//   DEPTH_WORDS  4096  number of 32-bit words in the array; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//   WAIT_CYCLES  1     extra wait states between accept and response (0..15)
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   req_valid  in   1   request present from MEM stage
//   req_ready  out  1   responder can accept; high only in IDLE
//   req_we     in   1   1 = store, 0 = load
//   req_fun3   in   3   funct3 of the access (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data, low-aligned: byte in [7:0], half in [15:0]
//   rsp_valid  out  1   response strobe, high exactly one cycle per accepted request
//   rsp_rdata  out  32  load data shifted to bit 0; unused upper bits zero; 0 for stores/errors
//   rsp_err    out  1   qualifies rsp_valid: misaligned, illegal funct3 or out-of-range
//   busy       out  1   high from accept until the end of the rsp_valid cycle
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
//     - Array contents are not reset.
//   FSM states:
//     IDLE -> accept when req_valid&&req_ready at an edge; capture we/fun3/addr/wdata into registers.
//             Inputs are don't-care after accept. Go to WAIT if WAIT_CYCLES>0, else RESP.
//     WAIT -> counter counts 1..WAIT_CYCLES; on count==WAIT_CYCLES go to RESP.
//     RESP -> rsp_valid=1 for this one cycle; next state IDLE.
//   Latency: accept at edge t0 -> rsp_valid high in the cycle after edge t0+WAIT_CYCLES.
//     - Minimum request spacing is WAIT_CYCLES+2 cycles; there is no back-to-back accept out of RESP.
//   Responses have no backpressure: the MEM stage holds its stall until rsp_valid.
//   Lane rules (off = addr[1:0], word index = addr[31:2]):
//     B/BU   : any off; store strobe = 4'b0001<<off, data = wdata[7:0]<<(8*off).
//     H/HU   : off must be 0 or 2; store strobe = 4'b0011<<off, data = wdata[15:0]<<(8*off).
//     W      : off must be 0; strobe = 4'b1111.
//     Load   : rdata = word>>(8*off), masked to 8 bits (B/BU), 16 bits (H/HU) or 32 bits (W).
//     Loads accept funct3 000,001,010,100,101. Stores accept 000,001,010.
//   Errors (rsp_err=1):
//     - Triggers: misaligned, illegal funct3, or addr >= 4*DEPTH_WORDS.
//     - Effect: no array write, rsp_rdata=0.
//     - Errors take the same latency as good requests.
//   Write commit:
//     - Strobed lanes are written at the edge entering RESP; unstrobed lanes are preserved.
//     - The read for a load is sampled at the same edge.
//     - rsp_rdata/rsp_err are registered there and hold until the next response edge.
//       Outside rsp_valid they are don't-care for consumers.
//   Reset mid-operation: return to IDLE immediately; a store not yet committed is dropped; no rsp_valid is produced.
//   req_valid during WAIT/RESP is ignored (req_ready=0); the requester must hold it until accepted.
// TESTING
//   1 Reset, WAIT_CYCLES=1:
//     - SW addr 0x10 wdata 0xDEADBEEF -> rsp_valid 2 cycles after accept, err=0.
//     - LW 0x10 -> rdata 0xDEADBEEF.
//   2 Word 0x10 = 0xDEADBEEF:
//     - SB addr 0x12 wdata 0x000000A5 -> word = 0xDEA5BEEF.
//     - LBU 0x13 -> rdata 0x000000DE.
//     - LH 0x12 -> rdata 0x0000DEA5 (zero-filled; no extension here).
//   3 Error cases:
//     - SH addr 0x11 -> rsp_err=1, word unchanged.
//     - LW 0x12 -> rsp_err=1, rdata 0.
//     - Load fun3 011 -> rsp_err=1.
//     - LW 4*DEPTH_WORDS -> rsp_err=1.
//   4 Handshake:
//     - Hold req_valid high continuously with two LW requests -> second accept no earlier than WAIT_CYCLES+2 cycles after first.
//     - req_addr changed after accept does not affect the response.
//   5 Reset mid-operation:
//     - Drop rst_n during WAIT of an SW 0x20 0x12345678 -> no rsp_valid, busy=0, req_ready=1.
//     - After rst_n=1, LW 0x20 returns the old contents.
//   6 WAIT_CYCLES=0 build:
//     - SW then LW same address -> each rsp_valid exactly 1 cycle after accept, data matches.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_fun3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_fun3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_fun3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, byte-lane store/load conversion,
// fixed wait states, single-cycle registered response with error flag.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  fun3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept, commit;

  logic        op_we;
  logic [2:0]  op_fun3;
  logic [31:0] op_addr, op_wdata;
  logic [1:0]  off;
  logic        legal, aligned, in_range, err;
  logic [3:0]  strb;
  logic [31:0] wdata_sh, rword, rshift, rmask;
  logic [AW-1:0] widx;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the commit edge is the accept edge, so decode from the
  // live request while idle and from the captured copy otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      op_we    = bus.req_we;
      op_fun3  = bus.req_fun3;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end else begin
      op_we    = we_q;
      op_fun3  = fun3_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  assign off      = op_addr[1:0];
  assign widx     = op_addr[AW+1:2];
  assign in_range = ({2'b00, op_addr[31:2]} < DEPTH_WORDS);

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    strb    = '0;
    case (op_fun3)
      3'b000: begin legal = 1'b1;   aligned = 1'b1;         strb = 4'b0001 << off; end
      3'b100: begin legal = !op_we; aligned = 1'b1;         strb = 4'b0001 << off; end
      3'b001: begin legal = 1'b1;   aligned = !off[0];      strb = 4'b0011 << off; end
      3'b101: begin legal = !op_we; aligned = !off[0];      strb = 4'b0011 << off; end
      3'b010: begin legal = 1'b1;   aligned = (off == 2'b00); strb = 4'b1111;      end
      default: ;
    endcase
  end

  assign err      = !(legal && aligned && in_range);
  assign wdata_sh = op_wdata << {off, 3'b000};
  assign rword    = mem[widx];
  assign rshift   = rword >> {off, 3'b000};

  always_comb begin
    case (op_fun3)
      3'b000, 3'b100: rmask = {24'h0, rshift[7:0]};
      3'b001, 3'b101: rmask = {16'h0, rshift[15:0]};
      default:        rmask = rshift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          state_d = S_RESP;
          commit  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      rdata_d = (err || op_we) ? '0 : rmask;
      err_d   = err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      fun3_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        fun3_q  <= bus.req_fun3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // Array is not reset; rst_n gating drops a store whose commit edge falls inside reset.
  always_ff @(posedge clk) begin
    if (rst_n && commit && op_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (strb[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one build with one wait state, one with none.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dmem_if bus1 ();
  dmem_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  dmem_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  virtual dmem_if vif;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the response cycle.
  task automatic xact(input bit d0, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    if (d0) vif = bus0; else vif = bus1;
    rdata = '0;
    err   = 1'b0;
    lat   = -1;
    vif.req_valid = 1'b1;
    vif.req_we    = we;
    vif.req_fun3  = f3;
    vif.req_addr  = addr;
    vif.req_wdata = wdata;
    n = 0;
    while (!vif.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) begin
      chk("accept_timeout", 32'd0, 32'd1);
      vif.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    vif.req_valid = 1'b0;
    vif.req_we    = ~we;
    vif.req_addr  = ~addr;
    vif.req_wdata = ~wdata;
    lat = 0;
    while (!vif.rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (lat == 50) chk("rsp_timeout", 32'd0, 32'd1);
    rdata = vif.rsp_rdata;
    err   = vif.rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          t, a0, a1;

    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_fun3 = '0;
    bus1.req_addr  = '0;   bus1.req_wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_fun3 = '0;
    bus0.req_addr  = '0;   bus0.req_wdata = '0;

    #12;
    chk("rst_ready", 32'(bus1.req_ready), 32'd1);
    chk("rst_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst_rdata", bus1.rsp_rdata, 32'h0);
    chk("rst_err",   32'(bus1.rsp_err), 32'd0);
    chk("rst_busy",  32'(bus1.busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xact(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd1);
    chk("sw_err", 32'(er), 32'd0);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd1);

    xact(0, 1'b1, 3'b000, 32'h12, 32'h000000A5, rd, er, lat);
    chk("sb_err", 32'(er), 32'd0);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("sb_word", rd, 32'hDEA5BEEF);
    xact(0, 1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
    chk("lbu_13", rd, 32'h000000DE);
    xact(0, 1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat);
    chk("lh_12", rd, 32'h0000DEA5);
    xact(0, 1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat);
    chk("lhu_10", rd, 32'h0000BEEF);
    xact(0, 1'b0, 3'b000, 32'h11, 32'h0, rd, er, lat);
    chk("lb_11", rd, 32'h000000BE);

    xact(0, 1'b1, 3'b001, 32'h11, 32'h00001234, rd, er, lat);
    chk("sh_mis_err", 32'(er), 32'd1);
    chk("sh_mis_rd",  rd, 32'h0);
    xact(0, 1'b1, 3'b100, 32'h10, 32'h00000077, rd, er, lat);
    chk("sbu_store_err", 32'(er), 32'd1);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("word_unchanged", rd, 32'hDEA5BEEF);
    xact(0, 1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rd",  rd, 32'h0);
    xact(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    chk("f3_011_err", 32'(er), 32'd1);
    xact(0, 1'b0, 3'b010, 32'h4000, 32'h0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_lat", 32'(lat), 32'd1);
    xact(0, 1'b0, 3'b010, 32'h3FFC, 32'h0, rd, er, lat);
    chk("last_word_err", 32'(er), 32'd0);

    // Continuous req_valid: second accept must wait out WAIT and RESP.
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_fun3 = 3'b010; bus1.req_addr = 32'h10;
    t = 0; a0 = -1; a1 = -1;
    while (a1 < 0 && t < 40) begin
      if (bus1.req_ready) begin
        if (a0 < 0) a0 = t; else a1 = t;
      end
      @(posedge clk); #1; t++;
    end
    bus1.req_valid = 1'b0;
    chk("b2b_gap_ok", 32'((a1 >= 0) && (a1 - a0 >= 3)), 32'd1);
    repeat (3) begin @(posedge clk); #1; end

    xact(0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rd, er, lat);
    chk("sw20_err", 32'(er), 32'd0);

    bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_fun3 = 3'b010;
    bus1.req_addr = 32'h20; bus1.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk("mid_busy_pre", 32'(bus1.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("mid_busy", 32'(bus1.busy), 32'd0);
    chk("mid_ready", 32'(bus1.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("mid_rsp_valid2", 32'(bus1.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rsp_valid3", 32'(bus1.rsp_valid), 32'd0);
    xact(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    chk("mid_old_data", rd, 32'hCAFEF00D);

    xact(1, 1'b1, 3'b010, 32'h40, 32'h13579BDF, rd, er, lat);
    chk("w0_sw_lat", 32'(lat), 32'd0);
    chk("w0_sw_err", 32'(er), 32'd0);
    xact(1, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    chk("w0_lw_lat", 32'(lat), 32'd0);
    chk("w0_lw_data", rd, 32'h13579BDF);
    xact(1, 1'b1, 3'b001, 32'h42, 32'hAAAA55AA, rd, er, lat);
    xact(1, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    chk("w0_sh_word", rd, 32'h55AA9BDF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
